// File: rtl/dmem_access_sequencer.sv
// MEM-stage data-memory sequencer: turns an EX/MEM load/store into a req/ready
// transaction, stalling the pipeline front and bubbling MEM/WB until it completes.
module dmem_access_sequencer #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              memwb_bubble,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   input  logic              err_clr,
   output logic              err
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Value of the counter during the last permitted BUSY cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op;
   logic             timeout_hit;

   assign op          = mem_read | mem_write;
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

   assign stall        = ((state == IDLE) && op) || (state == BUSY);
   assign memwb_bubble = stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         load_data  <= '0;
         load_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         // A timeout later in this block overrides the clear.
         if (err_clr) err <= 1'b0;
         case (state)
            IDLE: begin
               if (op) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write & ~mem_read;
                  dmem_addr  <= mem_addr;
                  dmem_wdata <= mem_wdata;
                  cnt        <= '0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (dmem_ready) begin
                  if (!dmem_we) load_data <= dmem_rdata;
                  load_valid <= ~dmem_we;
                  dmem_req   <= 1'b0;
                  state      <= DONE;
               end else if (timeout_hit) begin
                  if (!dmem_we) load_data <= '0;
                  load_valid <= ~dmem_we;
                  err        <= 1'b1;
                  dmem_req   <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               // Held instruction advances now; its op inputs must not re-issue.
               load_valid <= 1'b0;
               cnt        <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Self-checking bench for dmem_access_sequencer: directed vector table, reset and
// err_clr sequences, then random transactions checked against a transaction-level model.
module tb_dmem_access_sequencer;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          dmem_req, dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ready;
   logic [DW-1:0] dmem_rdata;
   logic          stall, memwb_bubble;
   logic [DW-1:0] load_data;
   logic          load_valid;
   logic          err_clr, err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .stall(stall), .memwb_bubble(memwb_bubble),
      .load_data(load_data), .load_valid(load_valid),
      .err_clr(err_clr), .err(err)
   );

   typedef struct {
      bit            rd, wr, clr;
      int            gap, lat;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rdata;
      int            exp_busy;
      bit            exp_we, exp_lv, exp_err;
      logic [DW-1:0] exp_ld;
   } vec_t;

   // Model state for the random phase.
   logic [DW-1:0] ld_m;
   bit            err_m;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      repeat (v.gap) begin
         mem_read = 0; mem_write = 0; dmem_ready = 0; err_clr = 0;
         @(negedge clk);
         chk("idle_stall", stall, 0);
         chk("idle_req", dmem_req, 0);
         chk("idle_lv", load_valid, 0);
         next_cycle();
      end
      mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
      dmem_ready = 0; err_clr = 0;
      @(negedge clk);
      chk("issue_stall", stall, 1);
      chk("issue_bubble", memwb_bubble, 1);
      chk("issue_req", dmem_req, 0);
      next_cycle();
      for (int k = 1; k <= v.exp_busy; k++) begin
         dmem_ready = (k == v.lat);
         dmem_rdata = dmem_ready ? v.rdata : $urandom;
         err_clr    = v.clr && (k == v.exp_busy);
         @(negedge clk);
         chk("busy_req", dmem_req, 1);
         chk("busy_stall", stall, 1);
         chk("busy_bubble", memwb_bubble, 1);
         chk("busy_we", dmem_we, v.exp_we);
         chk("busy_addr", dmem_addr, v.addr);
         if (v.exp_we) chk("busy_wdata", dmem_wdata, v.wdata);
         next_cycle();
      end
      // DONE: ready and op inputs must both be ignored.
      err_clr = 0; dmem_ready = 1'($urandom); dmem_rdata = $urandom;
      @(negedge clk);
      chk("done_stall", stall, 0);
      chk("done_bubble", memwb_bubble, 0);
      chk("done_req", dmem_req, 0);
      chk("done_lv", load_valid, v.exp_lv);
      chk("done_ld", load_data, v.exp_ld);
      chk("done_err", err, v.exp_err);
      next_cycle();
      dmem_ready = 0;
   endtask

   function automatic vec_t mk(bit rd, bit wr, int gap, int lat, bit clr, logic [AW-1:0] addr,
                               logic [DW-1:0] wdata, logic [DW-1:0] rdata, int busy, bit we,
                               bit lv, bit e, logic [DW-1:0] ld);
      vec_t v;
      v.rd = rd; v.wr = wr; v.gap = gap; v.lat = lat; v.clr = clr; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.exp_busy = busy; v.exp_we = we;
      v.exp_lv = lv; v.exp_err = e; v.exp_ld = ld;
      return v;
   endfunction

   vec_t tbl[10];

   initial begin
      tbl[0] = mk(1,0,1,3,0, 9'h01C, 32'h0,        32'hDEADBEEF, 3, 0, 1, 0, 32'hDEADBEEF);
      tbl[1] = mk(0,1,1,1,0, 9'h100, 32'h12345678, 32'h0,        1, 1, 0, 0, 32'hDEADBEEF);
      tbl[2] = mk(1,0,1,1,0, 9'h040, 32'h0,        32'hA5A50001, 1, 0, 1, 0, 32'hA5A50001);
      tbl[3] = mk(1,0,0,1,0, 9'h044, 32'h0,        32'h0000BEEF, 1, 0, 1, 0, 32'h0000BEEF);
      tbl[4] = mk(1,0,1,0,0, 9'h080, 32'h0,        32'h0,        4, 0, 1, 1, 32'h0);
      tbl[5] = mk(0,1,1,1,0, 9'h0F0, 32'h55AA55AA, 32'h0,        1, 1, 0, 1, 32'h0);
      tbl[6] = mk(1,0,1,4,1, 9'h0F4, 32'h0,        32'h11112222, 4, 0, 1, 0, 32'h11112222);
      tbl[7] = mk(1,0,1,4,0, 9'h0F8, 32'h0,        32'h33334444, 4, 0, 1, 0, 32'h33334444);
      tbl[8] = mk(1,1,1,2,0, 9'h1FF, 32'hFFFFFFFF, 32'hCAFEF00D, 2, 0, 1, 0, 32'hCAFEF00D);
      tbl[9] = mk(0,1,2,0,1, 9'h123, 32'h87654321, 32'h0,        4, 1, 0, 1, 32'hCAFEF00D);

      reset = 1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
      dmem_ready = 0; dmem_rdata = '0; err_clr = 0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_ld", load_data, 0);
      chk("rst_lv", load_valid, 0);
      chk("rst_err", err, 0);
      next_cycle();
      reset = 0;
      next_cycle();

      foreach (tbl[i]) run_txn(tbl[i]);

      // Standalone err_clr in IDLE.
      mem_read = 0; mem_write = 0; err_clr = 1;
      next_cycle();
      err_clr = 0;
      @(negedge clk);
      chk("errclr_err", err, 0);
      next_cycle();

      // Reset in the 2nd BUSY cycle, then a late ready.
      mem_read = 1; mem_addr = 9'h010;
      next_cycle();
      next_cycle();
      reset = 1;
      @(negedge clk);
      chk("rstmid_req_before", dmem_req, 1);
      next_cycle();
      reset = 0; mem_read = 0; dmem_ready = 1; dmem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("rstmid_req", dmem_req, 0);
      chk("rstmid_stall", stall, 0);
      chk("rstmid_lv", load_valid, 0);
      chk("rstmid_ld", load_data, 0);
      next_cycle();
      dmem_ready = 0;
      @(negedge clk);
      chk("rstmid_lv2", load_valid, 0);
      chk("rstmid_req2", dmem_req, 0);
      next_cycle();

      // Random transactions against a transaction-level model.
      ld_m = '0; err_m = 0;
      for (int n = 0; n < 60; n++) begin
         vec_t v;
         int   kind;
         bit   ok;
         kind    = $urandom_range(0, 2);
         v.rd    = (kind != 1);
         v.wr    = (kind != 0);
         v.gap   = $urandom_range(0, 2);
         v.lat   = $urandom_range(0, 6);
         v.clr   = 1'($urandom);
         v.addr  = AW'($urandom);
         v.wdata = $urandom;
         v.rdata = $urandom;
         ok         = (v.lat >= 1) && (v.lat <= TO);
         v.exp_busy = ok ? v.lat : TO;
         v.exp_we   = !v.rd;
         v.exp_lv   = v.rd;
         if (v.rd) ld_m = ok ? v.rdata : '0;
         if (!ok) err_m = 1;
         else if (v.clr) err_m = 0;
         v.exp_ld  = ld_m;
         v.exp_err = err_m;
         run_txn(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
